// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan-code constants, frame state encoding and the
// pause-sequence skip length. Used by the keyboard path and later the mouse path.
package ps2_pkg;

    localparam logic [7:0] PS2_E0     = 8'hE0;
    localparam logic [7:0] PS2_F0     = 8'hF0;
    localparam logic [7:0] PS2_E1     = 8'hE1;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;

    // Bytes following E1 in the Pause make/break sequence that carry no key info.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        FR_IDLE   = 2'd0,
        FR_DATA   = 2'd1,
        FR_PARITY = 2'd2,
        FR_STOP   = 2'd3
    } frame_state_t;

    // Keyboard housekeeping replies that are not key events on their own.
    function automatic logic is_line_code(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_RESEND) ||
               (b == PS2_ECHO) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Key-event and raw-byte bundle from the PS/2 receiver to the matrix logic.
interface ps2_kbd_rx_if;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       rx_byte_strobe;
    logic [7:0] rx_byte;
    logic       rx_err;

    modport master (
        output key_strobe, key_code, key_ext, key_release,
        output rx_byte_strobe, rx_byte, rx_err
    );

    modport slave (
        input key_strobe, key_code, key_ext, key_release,
        input rx_byte_strobe, rx_byte, rx_err
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for a PS/2 clock line.
// The filtered level flips only after FILT consecutive samples disagree with it;
// fall pulses for one cycle alongside the 1->0 flip.
module ps2_line_filter #(
    parameter int FILT = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic       sync_q1;
    logic       sync_q2;
    logic [3:0] run_cnt;

    // Bring the pin into the clk_sys domain; idle-high lines reset to 1.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= line_in;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            level   <= 1'b1;
            fall    <= 1'b0;
            run_cnt <= 4'd0;
        end else begin
            fall <= 1'b0;
            if (sync_q2 == level) begin
                run_cnt <= 4'd0;
            end else if (run_cnt == 4'(FILT - 1)) begin
                level   <= sync_q2;
                fall    <= ~sync_q2;
                run_cnt <= 4'd0;
            end else begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frames 11-bit serial words into bytes and folds the
// E0/F0/E1 prefixes into single key events for the keyboard matrix logic.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   FR_IDLE   | waiting for a falling edge with data low (start)
//   FR_DATA   | shifting in 8 data bits, LSB first
//   FR_PARITY | checking odd parity over data + parity bit
//   FR_STOP   | checking stop bit, handing good byte to decoder
module ps2_kbd_rx #(
    parameter int FILT    = 4,
    parameter int TIMEOUT = 10000
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ps2_kbd_clk,
    input  logic          ps2_kbd_data,
    ps2_kbd_rx_if.master  kbd
);

    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT);

    frame_state_t state_q, state_nxt;

    logic          clk_level;
    logic          clk_fall;
    logic [1:0]    data_sync;
    logic          data_bit;
    logic          sample_edge;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] tmr_q;
    logic          parity_ok;
    logic          timeout;
    logic          byte_good;
    logic          frame_err;
    logic          ext_q;
    logic          rel_q;
    logic [2:0]    skip_q;

    ps2_line_filter #(.FILT(FILT)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .line_in (ps2_kbd_clk),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    // Data only needs synchronizing; it is stable long before the filtered edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) data_sync <= 2'b11;
        else          data_sync <= {data_sync[0], ps2_kbd_data};
    end

    assign data_bit    = data_sync[1];
    assign sample_edge = clk_fall & ~clk_level;
    assign parity_ok   = ^{shift_q, data_bit};
    // A falling edge in the same cycle reloads the timer, so it beats the timeout.
    assign timeout     = (state_q != FR_IDLE) && !sample_edge && (tmr_q == '0);

    // Frame state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= FR_IDLE;
        else          state_q <= state_nxt;
    end

    // Frame next-state logic.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            FR_IDLE:   if (sample_edge && !data_bit)        state_nxt = FR_DATA;
            FR_DATA:   if (sample_edge && bit_cnt == 3'd7)  state_nxt = FR_PARITY;
            FR_PARITY: if (sample_edge) state_nxt = parity_ok ? FR_STOP : FR_IDLE;
            FR_STOP:   if (sample_edge)                     state_nxt = FR_IDLE;
            default:                                        state_nxt = FR_IDLE;
        endcase
        if (timeout) state_nxt = FR_IDLE;
    end

    // Frame outcome decode.
    always_comb begin
        byte_good = (state_q == FR_STOP) && sample_edge && data_bit;
        frame_err = timeout ||
                    ((state_q == FR_PARITY) && sample_edge && !parity_ok) ||
                    ((state_q == FR_STOP) && sample_edge && !data_bit);
    end

    // Shift register, bit counter and inter-edge down-counter.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= 8'd0;
            bit_cnt <= 3'd0;
            tmr_q   <= TW'(TIMEOUT - 1);
        end else begin
            if (sample_edge)
                tmr_q <= TW'(TIMEOUT - 1);
            else if (state_q != FR_IDLE && tmr_q != '0)
                tmr_q <= tmr_q - 1'b1;

            if (state_q == FR_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (state_q == FR_DATA && sample_edge) begin
                shift_q <= {data_bit, shift_q[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Prefix decoder and registered outputs; errors discard any pending prefix.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext_q              <= 1'b0;
            rel_q              <= 1'b0;
            skip_q             <= 3'd0;
            kbd.key_strobe     <= 1'b0;
            kbd.key_code       <= 8'd0;
            kbd.key_ext        <= 1'b0;
            kbd.key_release    <= 1'b0;
            kbd.rx_byte_strobe <= 1'b0;
            kbd.rx_byte        <= 8'd0;
            kbd.rx_err         <= 1'b0;
        end else begin
            kbd.key_strobe     <= 1'b0;
            kbd.rx_byte_strobe <= 1'b0;
            kbd.rx_err         <= frame_err;
            if (frame_err) begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end else if (byte_good) begin
                kbd.rx_byte_strobe <= 1'b1;
                kbd.rx_byte        <= shift_q;
                if (skip_q != 3'd0) begin
                    skip_q <= skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        kbd.key_strobe  <= 1'b1;
                        kbd.key_code    <= PS2_E1;
                        kbd.key_ext     <= 1'b0;
                        kbd.key_release <= 1'b0;
                    end
                end else if (shift_q == PS2_E1) begin
                    skip_q <= PAUSE_SKIP;
                end else if (shift_q == PS2_E0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == PS2_F0) begin
                    rel_q <= 1'b1;
                end else if (!(is_line_code(shift_q) && !ext_q && !rel_q)) begin
                    kbd.key_strobe  <= 1'b1;
                    kbd.key_code    <= shift_q;
                    kbd.key_ext     <= ext_q;
                    kbd.key_release <= rel_q;
                    ext_q           <= 1'b0;
                    rel_q           <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: expected bytes/key events are queued as frames
// are driven and checked when the receiver strobes them out.
module tb_ps2_kbd_rx;

    localparam int FILT    = 4;
    localparam int TIMEOUT = 10000;
    localparam int FAST    = 60;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_kbd_clk = 1'b1;
    logic ps2_kbd_data = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int exp_err  = 0;

    logic [7:0] exp_bytes[$];
    logic [9:0] exp_keys[$];

    ps2_kbd_rx_if kbd_if ();

    ps2_kbd_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data),
        .kbd          (kbd_if)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: compare every strobe against the scoreboard heads.
    always @(negedge clk_sys) begin
        logic [7:0] b;
        logic [9:0] k;
        if (kbd_if.rx_byte_strobe) begin
            if (exp_bytes.size() == 0) begin
                chk("byte_unexpected", {24'd0, kbd_if.rx_byte}, 32'hFFFF_FFFF);
            end else begin
                b = exp_bytes.pop_front();
                chk("rx_byte", {24'd0, kbd_if.rx_byte}, {24'd0, b});
            end
        end
        if (kbd_if.key_strobe) begin
            if (exp_keys.size() == 0) begin
                chk("key_unexpected", {22'd0, kbd_if.key_ext, kbd_if.key_release, kbd_if.key_code}, 32'hFFFF_FFFF);
            end else begin
                k = exp_keys.pop_front();
                chk("key_event", {22'd0, kbd_if.key_ext, kbd_if.key_release, kbd_if.key_code}, {22'd0, k});
            end
        end
        if (kbd_if.rx_err) begin
            err_seen++;
            chk("err_overlap", {30'd0, kbd_if.key_strobe, kbd_if.rx_byte_strobe}, 32'd0);
        end
    end

    task automatic push_key(input logic [7:0] code, input logic ext, input logic rel);
        exp_keys.push_back({ext, rel, code});
    endtask

    task automatic send_bit(input logic v, input int half, input bit glitch);
        ps2_kbd_data = v;
        if (glitch) begin
            repeat (half / 2) @(negedge clk_sys);
            ps2_kbd_clk = 1'b0;
            repeat (2) @(negedge clk_sys);
            ps2_kbd_clk = 1'b1;
            repeat (half - half / 2 - 2) @(negedge clk_sys);
        end else begin
            repeat (half) @(negedge clk_sys);
        end
        ps2_kbd_clk = 1'b0;
        repeat (half) @(negedge clk_sys);
        ps2_kbd_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int half, input bit bad_par,
                             input bit bad_stop, input bit glitch);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0, half, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], half, glitch);
        send_bit(par, half, glitch);
        send_bit(~bad_stop, half, glitch);
        ps2_kbd_data = 1'b1;
        repeat (20) @(negedge clk_sys);
    endtask

    // Good frame: expect the raw byte on the byte strobe.
    task automatic good_byte(input logic [7:0] b);
        exp_bytes.push_back(b);
        send_byte(b, FAST, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_key_strobe"},  {31'd0, kbd_if.key_strobe}, 32'd0);
        chk({tag, "_key_code"},    {24'd0, kbd_if.key_code}, 32'd0);
        chk({tag, "_key_ext"},     {31'd0, kbd_if.key_ext}, 32'd0);
        chk({tag, "_key_release"}, {31'd0, kbd_if.key_release}, 32'd0);
        chk({tag, "_byte_strobe"}, {31'd0, kbd_if.rx_byte_strobe}, 32'd0);
        chk({tag, "_rx_byte"},     {24'd0, kbd_if.rx_byte}, 32'd0);
        chk({tag, "_rx_err"},      {31'd0, kbd_if.rx_err}, 32'd0);
    endtask

    initial begin
        logic [7:0] brk;
        int hit;
        int limit;

        repeat (4) @(negedge clk_sys);
        check_outputs_zero("in_reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clk_sys);
        check_outputs_zero("after_reset");

        // Plain key at the nominal 2000-cycle bit period.
        exp_bytes.push_back(8'h1C);
        push_key(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C, 1000, 1'b0, 1'b0, 1'b0);
        chk("plain_bytes_left", exp_bytes.size(), 0);
        chk("plain_keys_left", exp_keys.size(), 0);

        // Extended release, then the same code plain.
        push_key(8'h75, 1'b1, 1'b1);
        good_byte(8'hE0);
        good_byte(8'hF0);
        good_byte(8'h75);
        push_key(8'h75, 1'b0, 1'b0);
        good_byte(8'h75);

        // Parity error, then recovery.
        exp_err++;
        send_byte(8'h1C, FAST, 1'b1, 1'b0, 1'b0);
        chk("parity_err_count", err_seen, exp_err);
        push_key(8'h1C, 1'b0, 1'b0);
        good_byte(8'h1C);

        // Stop-bit error.
        exp_err++;
        send_byte(8'h33, FAST, 1'b0, 1'b1, 1'b0);
        chk("stop_err_count", err_seen, exp_err);

        // Timeout mid-frame after 4 data bits; pending F0 must be discarded.
        good_byte(8'hF0);
        brk = 8'h1C;
        send_bit(1'b0, FAST, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(brk[i], FAST, 1'b0);
        ps2_kbd_data = brk[3];
        repeat (FAST) @(negedge clk_sys);
        ps2_kbd_clk = 1'b0;
        hit = 0;
        limit = FILT + 3 + TIMEOUT + 20;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk_sys);
            #1;
            if (k == FAST) ps2_kbd_clk = 1'b1;
            if (kbd_if.rx_err && hit == 0) hit = k;
        end
        @(negedge clk_sys);
        ps2_kbd_data = 1'b1;
        repeat (12000 - limit) @(negedge clk_sys);
        exp_err++;
        chk("timeout_cycle", hit, FILT + 3 + TIMEOUT);
        chk("timeout_err_count", err_seen, exp_err);
        push_key(8'h1C, 1'b0, 1'b0);
        good_byte(8'h1C);

        // Housekeeping code alone is dropped; with prefixes it is a key.
        good_byte(8'hFA);
        push_key(8'hAA, 1'b1, 1'b1);
        good_byte(8'hE0);
        good_byte(8'hF0);
        good_byte(8'hAA);

        // Pause sequence collapses to one E1 event.
        push_key(8'hE1, 1'b0, 1'b0);
        good_byte(8'hE1);
        good_byte(8'h14);
        good_byte(8'h77);
        good_byte(8'hE1);
        good_byte(8'hF0);
        good_byte(8'h14);
        good_byte(8'hF0);
        good_byte(8'h77);
        chk("pause_keys_left", exp_keys.size(), 0);

        // Short low glitches on the clock line, before and inside a frame.
        ps2_kbd_data = 1'b0;
        repeat (10) @(negedge clk_sys);
        ps2_kbd_clk = 1'b0;
        repeat (2) @(negedge clk_sys);
        ps2_kbd_clk = 1'b1;
        repeat (20) @(negedge clk_sys);
        ps2_kbd_data = 1'b1;
        repeat (10) @(negedge clk_sys);
        exp_bytes.push_back(8'h5A);
        push_key(8'h5A, 1'b0, 1'b0);
        send_byte(8'h5A, FAST, 1'b0, 1'b0, 1'b1);
        chk("glitch_err_count", err_seen, exp_err);

        // Reset during data bit 5, then a full 0x2A frame.
        brk = 8'h2A;
        send_bit(1'b0, FAST, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(brk[i], FAST, 1'b0);
        ps2_kbd_data = brk[5];
        repeat (FAST) @(negedge clk_sys);
        ps2_kbd_clk = 1'b0;
        repeat (10) @(negedge clk_sys);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_outputs_zero("mid_reset");
        reset_n = 1'b1;
        repeat (FAST - 13) @(negedge clk_sys);
        ps2_kbd_clk = 1'b1;
        ps2_kbd_data = 1'b1;
        repeat (200) @(negedge clk_sys);
        chk("reset_err_count", err_seen, exp_err);
        push_key(8'h2A, 1'b0, 1'b0);
        good_byte(8'h2A);

        repeat (50) @(negedge clk_sys);
        chk("final_bytes_left", exp_bytes.size(), 0);
        chk("final_keys_left", exp_keys.size(), 0);
        chk("final_err_count", err_seen, exp_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
